traffic_phase_sequencer: RTL and testbench
==========================================

// Module: traffic_phase_sequencer
// PURPOSE
//   Timed phase sequencer for a main/side road junction with pedestrian walk and a flash (fault) mode.
//   Drives the seven lamp lines of the Lights stage (Rm Ym Gm Rs Ys Gs W) directly.
//   All phase durations are parameters, counted in ticks of an external timebase.
//   Replaces the hand-driven one-hot light_signals stimulus with an autonomous FSM.
// PARAMETERS
//   CNT_W          8  timer width; every duration must be <= 2**CNT_W
//   MAIN_GREEN_MIN 8  minimum main-green ticks before a request is served
//   MAIN_YELLOW    3  main-yellow ticks
//   ALL_RED        2  all-red clearance ticks (used by both clearance states)
//   SIDE_GREEN     6  side-green ticks
//   SIDE_YELLOW    3  side-yellow ticks
//   WALK_TIME      5  walk ticks in total; all durations must be >= 1
//   WALK_BLINK     2  final ticks of walk during which W blinks; must be < WALK_TIME
// PORTS
//   clk          in   1  clock, rising edge
//   reset_n      in   1  asynchronous active-low reset
//   tick         in   1  timebase enable, 1-cycle pulse; timer and blink advance only when high
//   side_car     in   1  side-road vehicle sensor (level)
//   ped_req      in   1  pedestrian button (pulse or level)
//   flash_en     in   1  maintenance/fault flash request (level)
//   Rm Ym Gm     out  1  main-road red/yellow/green lamps, registered
//   Rs Ys Gs     out  1  side-road red/yellow/green lamps, registered
//   W            out  1  walk lamp, registered
//   phase        out  3  current state code, for debug
// BEHAVIOUR
//   - State codes: MG=0, MY=1, AR1=2, SG=3, SY=4, AR2=5, WALK=6, FLASH=7.
//   - Reset (async): state=MG, timer=MAIN_GREEN_MIN-1, ped_pending=0, blink=0.
//     Outputs on reset: Gm=1, Rs=1, all other lamps 0.
//   - Timer: on entry to a state, load DUR-1. On a tick with timer>0, decrement.
//     A tick with timer==0 is "expiry". A timed state therefore lasts exactly DUR ticks.
//   - Transitions, evaluated only on expiry ticks:
//       MG   -> MY when side_car | ped_pending; otherwise hold at timer=0.
//       MY   -> AR1.
//       AR1  -> WALK if ped_pending, else SG.
//       WALK -> SG if side_car, else MG.
//       SG   -> SY.
//       SY   -> AR2.
//       AR2  -> MG.
//   - Lamps per state:
//       MG:      Gm, Rs
//       MY:      Ym, Rs
//       AR1/AR2: Rm, Rs
//       SG:      Rm, Gs
//       SY:      Rm, Ys
//       WALK:    Rm, Rs, W
//   - Walk blink: W is steady 1 for the first WALK_TIME-WALK_BLINK ticks.
//     In the last WALK_BLINK ticks, W toggles on every tick, starting at 0.
//   - ped_pending: set by ped_req in any state; cleared on the edge that enters WALK.
//     If ped_req and WALK entry occur in the same cycle, clear wins.
//   - flash_en=1: on the next clk edge, any state goes to FLASH, regardless of tick.
//     FLASH lamps: Ym and Rs toggle together on every tick, starting at 1; all other lamps 0.
//     ped_pending is held during FLASH.
//   - flash_en=0 while in FLASH: on the next edge, go to AR2 (timer=ALL_RED-1), then MG.
//   - tick=0: state, timer and blink are frozen. Only flash entry/exit and ped_pending capture proceed.
//   - Lamp outputs update on the same edge as the state change. There is no extra latency.
//   - At most one green lamp is on at any time. Never Gm&Gs, and never W with Gm or Gs.
//   - Reset asserted mid-phase: outputs return to reset values immediately, without waiting for clk.
// TESTING
//   1. tick=1, no requests, 50 cycles -> Gm=Rs=1 throughout; phase=0.
//   2. tick=1, side_car=1 from reset -> durations in cycles: Gm 8, Ym 3, all-red 2, Gs 6, Ys 3, all-red 2;
//      Gm returns at cycle 24.
//   3. tick=1, ped_req pulse at cycle 2, side_car=0 -> Ym at cycle 8, AR1 at 11, WALK at 13 (W=1,1,1,0,1),
//      MG at 18; ped_pending=0 once WALK is entered.
//   4. flash_en=1 at cycle 16 of test 2 (SG) -> FLASH at 17, Gs=0, Ym/Rs=1,0,1,0...;
//      flash_en=0 -> AR2 for 2 cycles, then MG with a full 8-cycle minimum green.
//   5. tick every 4th cycle, side_car=1 -> every phase lasts 4x cycles;
//      no state or timer change on non-tick cycles.
//   6. reset_n low mid-SY with ped_pending=1 -> lamps go to Gm=Rs=1 asynchronously;
//      after release, no WALK occurs without a new ped_req.

Source files
------------

// File: rtl/traffic_phase_sequencer.sv
// Autonomous main/side junction sequencer with pedestrian walk phase and flash mode.
// Lamp outputs are registered from next-state values so they change on the same edge as the state.
module traffic_phase_sequencer #(
    parameter int CNT_W          = 8,
    parameter int MAIN_GREEN_MIN = 8,
    parameter int MAIN_YELLOW    = 3,
    parameter int ALL_RED        = 2,
    parameter int SIDE_GREEN     = 6,
    parameter int SIDE_YELLOW    = 3,
    parameter int WALK_TIME      = 5,
    parameter int WALK_BLINK     = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick,
    input  logic       side_car,
    input  logic       ped_req,
    input  logic       flash_en,
    output logic       Rm,
    output logic       Ym,
    output logic       Gm,
    output logic       Rs,
    output logic       Ys,
    output logic       Gs,
    output logic       W,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        MG    = 3'd0,
        MY    = 3'd1,
        AR1   = 3'd2,
        SG    = 3'd3,
        SY    = 3'd4,
        AR2   = 3'd5,
        WALK  = 3'd6,
        FLASH = 3'd7
    } state_t;

    localparam logic [CNT_W-1:0] T_MG = CNT_W'(MAIN_GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] T_MY = CNT_W'(MAIN_YELLOW - 1);
    localparam logic [CNT_W-1:0] T_AR = CNT_W'(ALL_RED - 1);
    localparam logic [CNT_W-1:0] T_SG = CNT_W'(SIDE_GREEN - 1);
    localparam logic [CNT_W-1:0] T_SY = CNT_W'(SIDE_YELLOW - 1);
    localparam logic [CNT_W-1:0] T_WK = CNT_W'(WALK_TIME - 1);
    localparam logic [CNT_W-1:0] T_WB = CNT_W'(WALK_BLINK);

    state_t           state, state_n;
    logic [CNT_W-1:0] timer, timer_n, timer_dec;
    logic             blink, blink_n;
    logic             ped_pending, ped_pending_n;
    logic [6:0]       lamps_n;

    function automatic logic [CNT_W-1:0] dur(input state_t s);
        case (s)
            MG:       dur = T_MG;
            MY:       dur = T_MY;
            AR1, AR2: dur = T_AR;
            SG:       dur = T_SG;
            SY:       dur = T_SY;
            WALK:     dur = T_WK;
            default:  dur = '0;
        endcase
    endfunction

    assign timer_dec = timer - 1'b1;

    always_comb begin
        state_n = state;
        timer_n = timer;
        blink_n = blink;
        if (flash_en && state != FLASH) begin
            state_n = FLASH;
            blink_n = 1'b1;
        end else if (!flash_en && state == FLASH) begin
            state_n = AR2;
            timer_n = T_AR;
        end else if (state == FLASH) begin
            if (tick)
                blink_n = ~blink;
        end else if (tick) begin
            if (timer != '0) begin
                timer_n = timer_dec;
                // W blinks over the last WALK_BLINK ticks, first blink tick dark
                if (state == WALK && timer_dec < T_WB)
                    blink_n = (timer_dec == T_WB - 1'b1) ? 1'b0 : ~blink;
            end else begin
                case (state)
                    MG:      if (side_car || ped_pending) state_n = MY;
                    MY:      state_n = AR1;
                    AR1:     state_n = ped_pending ? WALK : SG;
                    WALK:    state_n = side_car ? SG : MG;
                    SG:      state_n = SY;
                    SY:      state_n = AR2;
                    AR2:     state_n = MG;
                    default: state_n = MG;
                endcase
                if (state_n != state)
                    timer_n = dur(state_n);
            end
        end
    end

    // Clearing on WALK entry overrides a simultaneous request.
    assign ped_pending_n = (ped_pending | ped_req) & ~(state_n == WALK && state != WALK);

    // lamps_n = {Rm, Ym, Gm, Rs, Ys, Gs, W}
    always_comb begin
        lamps_n = 7'b0;
        case (state_n)
            MG:       lamps_n = 7'b0011000;
            MY:       lamps_n = 7'b0101000;
            AR1, AR2: lamps_n = 7'b1001000;
            SG:       lamps_n = 7'b1000010;
            SY:       lamps_n = 7'b1000100;
            WALK:     lamps_n = {6'b100100, (timer_n >= T_WB) ? 1'b1 : blink_n};
            FLASH:    lamps_n = {1'b0, blink_n, 1'b0, blink_n, 3'b000};
            default:  lamps_n = 7'b0011000;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= MG;
            timer       <= T_MG;
            blink       <= 1'b0;
            ped_pending <= 1'b0;
            {Rm, Ym, Gm, Rs, Ys, Gs, W} <= 7'b0011000;
        end else begin
            state       <= state_n;
            timer       <= timer_n;
            blink       <= blink_n;
            ped_pending <= ped_pending_n;
            {Rm, Ym, Gm, Rs, Ys, Gs, W} <= lamps_n;
        end
    end

    assign phase = state;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Directed bench for traffic_phase_sequencer: phase timing, walk blink, flash, tick gating, async reset.
module tb_traffic_phase_sequencer;

    localparam logic [2:0] P_MG = 3'd0, P_MY = 3'd1, P_AR1 = 3'd2, P_SG = 3'd3,
                           P_SY = 3'd4, P_AR2 = 3'd5, P_WK = 3'd6, P_FL = 3'd7;
    // {Rm, Ym, Gm, Rs, Ys, Gs, W}
    localparam logic [6:0] L_MG = 7'b0011000, L_MY = 7'b0101000, L_AR = 7'b1001000,
                           L_SG = 7'b1000010, L_SY = 7'b1000100, L_W1 = 7'b1001001,
                           L_W0 = 7'b1001000, L_F1 = 7'b0101000, L_F0 = 7'b0000000;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       tick = 1'b1, side_car = 1'b0, ped_req = 1'b0, flash_en = 1'b0;
    logic       Rm, Ym, Gm, Rs, Ys, Gs, W;
    logic [2:0] phase;

    int n_cmp = 0, n_bad = 0;
    int tdiv = 1, tcnt = 0;
    bit chk_on = 1'b0;

    traffic_phase_sequencer dut (
        .clk(clk), .reset_n(reset_n), .tick(tick), .side_car(side_car),
        .ped_req(ped_req), .flash_en(flash_en),
        .Rm(Rm), .Ym(Ym), .Gm(Gm), .Rs(Rs), .Ys(Ys), .Gs(Gs), .W(W),
        .phase(phase)
    );

    always #5 clk = ~clk;

    wire [9:0] obs = {phase, Rm, Ym, Gm, Rs, Ys, Gs, W};

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; tick pattern is high on every tdiv-th cycle.
    task automatic cyc();
        @(posedge clk);
        #1;
        tcnt = (tcnt + 1) % tdiv;
        tick = (tcnt == tdiv - 1);
    endtask

    // Check the expected phase/lamps on the current cycle, then advance, n times.
    task automatic hold(input string tag, input logic [2:0] ph, input logic [6:0] lm, input int n);
        repeat (n) begin
            chk(tag, {6'b0, obs}, {6'b0, ph, lm});
            cyc();
        end
    endtask

    // Assert reset between edges, check the async lamp values, release just after an edge.
    task automatic rst_seq();
        reset_n = 1'b0;
        #2;
        chk("rst_async", {6'b0, obs}, {6'b0, P_MG, L_MG});
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tcnt = 0;
        tick = (tdiv == 1);
        chk_on = 1'b1;
    endtask

    always @(negedge clk)
        if (chk_on)
            chk("one_green", {15'b0, (Gm & Gs) | (W & (Gm | Gs))}, 16'h0);

    initial begin
        #3;
        // 1: idle main green
        rst_seq();
        hold("t1_mg", P_MG, L_MG, 50);

        // 2: full cycle on side demand
        side_car = 1'b1;
        rst_seq();
        hold("t2_mg", P_MG, L_MG, 8);
        hold("t2_my", P_MY, L_MY, 3);
        hold("t2_ar1", P_AR1, L_AR, 2);
        hold("t2_sg", P_SG, L_SG, 6);
        hold("t2_sy", P_SY, L_SY, 3);
        hold("t2_ar2", P_AR2, L_AR, 2);
        hold("t2_mg24", P_MG, L_MG, 1);

        // 3: pedestrian walk, request coinciding with WALK entry is dropped
        side_car = 1'b0;
        rst_seq();
        hold("t3_mg", P_MG, L_MG, 2);
        ped_req = 1'b1;
        hold("t3_mg", P_MG, L_MG, 1);
        ped_req = 1'b0;
        hold("t3_mg", P_MG, L_MG, 5);
        hold("t3_my", P_MY, L_MY, 3);
        hold("t3_ar1", P_AR1, L_AR, 1);
        ped_req = 1'b1;
        hold("t3_ar1", P_AR1, L_AR, 1);
        ped_req = 1'b0;
        hold("t3_w_on", P_WK, L_W1, 3);
        hold("t3_w_off", P_WK, L_W0, 1);
        hold("t3_w_on2", P_WK, L_W1, 1);
        hold("t3_mg_idle", P_MG, L_MG, 20);

        // 4: flash from side green, then recovery through AR2
        side_car = 1'b1;
        rst_seq();
        hold("t4_mg", P_MG, L_MG, 8);
        hold("t4_my", P_MY, L_MY, 3);
        hold("t4_ar1", P_AR1, L_AR, 2);
        hold("t4_sg", P_SG, L_SG, 3);
        flash_en = 1'b1;
        hold("t4_sg16", P_SG, L_SG, 1);
        hold("t4_fl1", P_FL, L_F1, 1);
        hold("t4_fl0", P_FL, L_F0, 1);
        hold("t4_fl1", P_FL, L_F1, 1);
        hold("t4_fl0", P_FL, L_F0, 1);
        flash_en = 1'b0;
        hold("t4_fl1", P_FL, L_F1, 1);
        hold("t4_ar2", P_AR2, L_AR, 2);
        hold("t4_mg", P_MG, L_MG, 8);
        hold("t4_my", P_MY, L_MY, 1);

        // 5: tick every 4th cycle stretches every phase 4x; flash ignores tick
        tdiv = 4;
        rst_seq();
        hold("t5_mg", P_MG, L_MG, 32);
        hold("t5_my", P_MY, L_MY, 12);
        hold("t5_ar1", P_AR1, L_AR, 8);
        hold("t5_sg", P_SG, L_SG, 24);
        hold("t5_sy", P_SY, L_SY, 12);
        hold("t5_ar2", P_AR2, L_AR, 8);
        flash_en = 1'b1;
        hold("t5_mg96", P_MG, L_MG, 1);
        hold("t5_fl1", P_FL, L_F1, 3);
        flash_en = 1'b0;
        hold("t5_fl0", P_FL, L_F0, 1);
        hold("t5_ar2x", P_AR2, L_AR, 7);
        hold("t5_mg", P_MG, L_MG, 1);

        // 6: reset mid side-yellow discards a pending walk
        tdiv = 1;
        rst_seq();
        hold("t6_mg", P_MG, L_MG, 8);
        hold("t6_my", P_MY, L_MY, 3);
        hold("t6_ar1", P_AR1, L_AR, 2);
        hold("t6_sg", P_SG, L_SG, 1);
        ped_req = 1'b1;
        hold("t6_sg", P_SG, L_SG, 1);
        ped_req = 1'b0;
        hold("t6_sg", P_SG, L_SG, 4);
        hold("t6_sy", P_SY, L_SY, 1);
        side_car = 1'b0;
        rst_seq();
        hold("t6_mg_idle", P_MG, L_MG, 30);

        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
